// File: rtl/conv_job_scheduler.sv
// ============================================================================
// conv_job_scheduler: queues convolution jobs and sequences the fetch unit one
// frame at a time, arbitrates the image BRAM port, and reports per-job status.
// Optional watchdog: CONV_WDOG_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module conv_job_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int QDEPTH     = 4,
  parameter int TAG_W      = 4,
  parameter int WDOG_CYC   = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_job_valid,
  output logic                  o_job_ready,
  input  logic [ADDR_WIDTH-1:0] i_job_base_addr,
  input  logic [2:0]            i_job_ker_size,
  input  logic [4:0]            i_job_img_size,
  input  logic [TAG_W-1:0]      i_job_tag,
  output logic                  o_fu_start,
  output logic [ADDR_WIDTH-1:0] o_fu_base_addr,
  output logic [2:0]            o_fu_ker_size,
  output logic [4:0]            o_fu_img_size,
  input  logic                  i_fu_window_valid,
  input  logic                  i_fu_frame_done,
  input  logic                  i_fu_bram_en,
  input  logic [ADDR_WIDTH-1:0] i_fu_bram_addr,
  input  logic                  i_host_req,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_wdata,
  output logic                  o_host_gnt,
  output logic                  o_bram_en,
  output logic                  o_bram_we,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0] o_bram_wdata,
  output logic                  o_done_valid,
  input  logic                  i_done_ready,
  output logic [TAG_W-1:0]      o_done_tag,
  output logic [15:0]           o_done_windows,
  output logic [1:0]            o_done_err,
  output logic                  o_busy
);

  localparam int c_AW = $clog2(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t r_state;

  // Job queue storage; pointers carry one extra wrap bit to tell full from empty
  logic [ADDR_WIDTH-1:0] r_q_base [QDEPTH];
  logic [2:0]            r_q_ker  [QDEPTH];
  logic [4:0]            r_q_img  [QDEPTH];
  logic [TAG_W-1:0]      r_q_tag  [QDEPTH];
  logic [c_AW:0]         r_wr_ptr;
  logic [c_AW:0]         r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_push  = i_job_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;

  assign o_job_ready = !w_full;
  assign o_busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_base[r_wr_ptr[c_AW-1:0]] <= i_job_base_addr;
      r_q_ker[r_wr_ptr[c_AW-1:0]]  <= i_job_ker_size;
      r_q_img[r_wr_ptr[c_AW-1:0]]  <= i_job_img_size;
      r_q_tag[r_wr_ptr[c_AW-1:0]]  <= i_job_tag;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Fetch unit has priority; the host only writes when the port is free
  assign o_host_gnt   = i_host_req && !i_fu_bram_en;
  assign o_bram_en    = i_fu_bram_en | o_host_gnt;
  assign o_bram_we    = o_host_gnt;
  assign o_bram_addr  = i_fu_bram_en ? i_fu_bram_addr : i_host_addr;
  assign o_bram_wdata = o_host_gnt ? i_host_wdata : '0;

  logic [ADDR_WIDTH-1:0] r_fu_base;
  logic [2:0]            r_fu_ker;
  logic [4:0]            r_fu_img;
  logic [TAG_W-1:0]      r_cur_tag;
  logic                  r_fu_start;
  logic [15:0]           r_win_cnt;
  logic                  r_done_valid;
  logic [TAG_W-1:0]      r_done_tag;
  logic [15:0]           r_done_windows;
  logic [1:0]            r_done_err;

  logic        w_cfg_ok;
  logic [4:0]  w_side;
  logic [9:0]  w_side_sq;
  logic [15:0] w_expect;
  logic [15:0] w_win_next;

  assign w_cfg_ok   = ((r_fu_ker == 3'd2) || (r_fu_ker == 3'd3) || (r_fu_ker == 3'd5)) &&
                      (r_fu_img >= {2'b00, r_fu_ker});
  assign w_side     = r_fu_img - {2'b00, r_fu_ker} + 5'd1;
  assign w_side_sq  = {5'd0, w_side} * {5'd0, w_side};
  assign w_expect   = {6'd0, w_side_sq};
  // Includes a window arriving in the same cycle as frame_done
  assign w_win_next = (i_fu_window_valid && (r_win_cnt != 16'hFFFF)) ?
                      r_win_cnt + 16'd1 : r_win_cnt;

`ifdef CONV_WDOG_EN
  localparam int c_WD_W = $clog2(WDOG_CYC) + 1;
  logic [c_WD_W-1:0] r_wdog;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_fu_base      <= '0;
      r_fu_ker       <= '0;
      r_fu_img       <= '0;
      r_cur_tag      <= '0;
      r_fu_start     <= 1'b0;
      r_win_cnt      <= '0;
      r_done_valid   <= 1'b0;
      r_done_tag     <= '0;
      r_done_windows <= '0;
      r_done_err     <= '0;
`ifdef CONV_WDOG_EN
      r_wdog         <= '0;
`endif
    end else begin
      r_fu_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_fu_base <= r_q_base[r_rd_ptr[c_AW-1:0]];
            r_fu_ker  <= r_q_ker[r_rd_ptr[c_AW-1:0]];
            r_fu_img  <= r_q_img[r_rd_ptr[c_AW-1:0]];
            r_cur_tag <= r_q_tag[r_rd_ptr[c_AW-1:0]];
            r_win_cnt <= '0;
            r_state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (!w_cfg_ok) begin
            r_done_valid   <= 1'b1;
            r_done_tag     <= r_cur_tag;
            r_done_windows <= '0;
            r_done_err     <= 2'd1;
            r_state        <= S_REPORT;
          end else begin
            r_fu_start <= 1'b1;
`ifdef CONV_WDOG_EN
            r_wdog     <= '0;
`endif
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_win_cnt <= w_win_next;
          if (i_fu_frame_done) begin
            r_done_valid   <= 1'b1;
            r_done_tag     <= r_cur_tag;
            r_done_windows <= w_win_next;
            r_done_err     <= (w_win_next != w_expect) ? 2'd2 : 2'd0;
            r_state        <= S_REPORT;
          end
`ifdef CONV_WDOG_EN
          else if (r_wdog == c_WD_W'(WDOG_CYC - 1)) begin
            r_done_valid   <= 1'b1;
            r_done_tag     <= r_cur_tag;
            r_done_windows <= w_win_next;
            r_done_err     <= 2'd3;
            r_state        <= S_REPORT;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
`endif
        end
        S_REPORT: begin
          if (i_done_ready) begin
            r_done_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_fu_start     = r_fu_start;
  assign o_fu_base_addr = r_fu_base;
  assign o_fu_ker_size  = r_fu_ker;
  assign o_fu_img_size  = r_fu_img;
  assign o_done_valid   = r_done_valid;
  assign o_done_tag     = r_done_tag;
  assign o_done_windows = r_done_windows;
  assign o_done_err     = r_done_err;

endmodule

`default_nettype wire

// File: tb/tb_conv_job_scheduler.sv
// ============================================================================
// tb_conv_job_scheduler: directed stimulus with a completion scoreboard and a
// behavioural fetch-unit responder.   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_conv_job_scheduler;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          job_valid, job_ready;
  logic [AW-1:0] job_base;
  logic [2:0]    job_ker;
  logic [4:0]    job_img;
  logic [TW-1:0] job_tag;
  logic          fu_start;
  logic [AW-1:0] fu_base;
  logic [2:0]    fu_ker;
  logic [4:0]    fu_img;
  logic          fu_window_valid, fu_frame_done, fu_bram_en;
  logic [AW-1:0] fu_bram_addr;
  logic          host_req, host_gnt;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;
  logic          done_valid, done_ready;
  logic [TW-1:0] done_tag;
  logic [15:0]   done_windows;
  logic [1:0]    done_err;
  logic          busy;

  always #5 clk = ~clk;

  conv_job_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .QDEPTH(4), .TAG_W(TW), .WDOG_CYC(64)) dut (
    .clk(clk), .rstn(rstn),
    .i_job_valid(job_valid), .o_job_ready(job_ready), .i_job_base_addr(job_base),
    .i_job_ker_size(job_ker), .i_job_img_size(job_img), .i_job_tag(job_tag),
    .o_fu_start(fu_start), .o_fu_base_addr(fu_base), .o_fu_ker_size(fu_ker),
    .o_fu_img_size(fu_img), .i_fu_window_valid(fu_window_valid),
    .i_fu_frame_done(fu_frame_done), .i_fu_bram_en(fu_bram_en), .i_fu_bram_addr(fu_bram_addr),
    .i_host_req(host_req), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_gnt(host_gnt), .o_bram_en(bram_en), .o_bram_we(bram_we),
    .o_bram_addr(bram_addr), .o_bram_wdata(bram_wdata), .o_done_valid(done_valid),
    .i_done_ready(done_ready), .o_done_tag(done_tag), .o_done_windows(done_windows),
    .o_done_err(done_err), .o_busy(busy)
  );

  typedef struct { int tag; int win; int err; } exp_t;
  typedef struct { int nwin; bit same; bit nodone; } fu_t;
  exp_t sb[$];
  fu_t  fq[$];

  int n_chk = 0, n_fail = 0, n_starts = 0, exp_starts = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_job(input int tag, input int ker, input int img, input int base);
    int t = 0;
    @(negedge clk);
    while (!job_ready && t < 300) begin @(negedge clk); t++; end
    if (!job_ready) chk("push_ready_timeout", 32'(job_ready), 32'd1);
    job_base  = AW'(base);
    job_ker   = 3'(ker);
    job_img   = 5'(img);
    job_tag   = TW'(tag);
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 5000) begin @(negedge clk); t++; end
    chk("drain_scoreboard", 32'(sb.size()), 32'd0);
  endtask

  // Fetch-unit responder: reacts to fu_start with the next queued frame profile
  initial begin
    fu_t e;
    fu_window_valid = 1'b0;
    fu_frame_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && fu_start && fq.size() != 0) begin
        e = fq.pop_front();
        @(posedge clk); #1;
        for (int i = 0; i < e.nwin; i++) begin
          fu_window_valid = 1'b1;
          fu_frame_done   = e.same && !e.nodone && (i == e.nwin - 1);
          @(posedge clk); #1;
        end
        fu_window_valid = 1'b0;
        fu_frame_done   = 1'b0;
        if (!e.same && !e.nodone) begin
          fu_frame_done = 1'b1;
          @(posedge clk); #1;
          fu_frame_done = 1'b0;
        end
      end
    end
  end

  // Completion monitor: scoreboard compare on handshake, stability while stalled
  logic          hold = 1'b0;
  logic [TW-1:0] p_tag;
  logic [15:0]   p_win;
  logic [1:0]    p_err;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hold = 1'b0;
      end else begin
        if (fu_start) n_starts++;
        if (done_valid && hold) begin
          chk("stable_tag", 32'(done_tag), 32'(p_tag));
          chk("stable_windows", 32'(done_windows), 32'(p_win));
          chk("stable_err", 32'(done_err), 32'(p_err));
        end
        if (done_valid && done_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("done_tag", 32'(done_tag), 32'(e.tag));
            chk("done_windows", 32'(done_windows), 32'(e.win));
            chk("done_err", 32'(done_err), 32'(e.err));
          end
        end
        hold  = done_valid && !done_ready;
        p_tag = done_tag;
        p_win = done_windows;
        p_err = done_err;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int kers [5] = '{2, 3, 5, 2, 3};
    int imgs [5] = '{2, 4, 5, 3, 5};
    int nwin [5] = '{1, 4, 1, 4, 9};
    bit same [5] = '{1, 0, 0, 1, 0};
    bit [7:0] pat_en  = 8'b0101_1010;
    bit [7:0] pat_req = 8'b1111_0111;
    int seen, base_starts, t;

    job_valid = 0; job_base = '0; job_ker = '0; job_img = '0; job_tag = '0;
    fu_bram_en = 0; fu_bram_addr = '0; host_req = 0; host_addr = '0; host_wdata = '0;
    done_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fu_start", 32'(fu_start), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_bram_en", 32'(bram_en), 32'd0);
    chk("rst_fu_img", 32'(fu_img), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Nominal 28x28 frame, 3x3 kernel: 676 windows, last one with frame_done
    fq.push_back('{676, 1'b1, 1'b0});
    sb.push_back('{1, 676, 0});
    exp_starts++;
    push_job(1, 3, 28, 0);
    @(negedge clk); chk("lat_start_e0", 32'(fu_start), 32'd0);
    @(negedge clk); chk("lat_start_e1", 32'(fu_start), 32'd0);
    @(negedge clk); chk("lat_start_e2", 32'(fu_start), 32'd1);
    chk("cfg_base", 32'(fu_base), 32'h000);
    chk("cfg_ker", 32'(fu_ker), 32'd3);
    chk("cfg_img", 32'(fu_img), 32'd28);
    @(negedge clk); chk("lat_start_e3", 32'(fu_start), 32'd0);
    chk("cfg_img_hold", 32'(fu_img), 32'd28);
    drain();

    // Illegal kernel size and image smaller than kernel
    base_starts = n_starts;
    sb.push_back('{2, 0, 1});
    push_job(2, 4, 8, 'h100);
    seen = 0;
    for (int i = 0; i < 3 && !seen; i++) begin
      @(negedge clk);
      if (done_valid) seen = 1;
    end
    chk("err_cfg_latency", 32'(seen), 32'd1);
    drain();
    sb.push_back('{5, 0, 1});
    push_job(5, 5, 3, 'h100);
    drain();
    chk("err_cfg_no_start", 32'(n_starts), 32'(base_starts));

    // BRAM arbitration with host request held across fetch reads
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      fu_bram_en   = pat_en[i];
      fu_bram_addr = AW'(12'h0A0 + i);
      host_req     = pat_req[i];
      host_addr    = AW'(12'h300 + i);
      host_wdata   = 32'hDEAD_BE00 + DW'(i);
      @(negedge clk);
      chk("arb_gnt", 32'(host_gnt), 32'(pat_req[i] && !pat_en[i]));
      chk("arb_we", 32'(bram_we), 32'(pat_req[i] && !pat_en[i]));
      chk("arb_en", 32'(bram_en), 32'(pat_req[i] || pat_en[i]));
      chk("arb_addr", 32'(bram_addr), pat_en[i] ? 32'(12'h0A0 + i) : 32'(12'h300 + i));
      chk("arb_wdata", bram_wdata, (pat_req[i] && !pat_en[i]) ? 32'hDEAD_BE00 + i : 32'd0);
    end
    @(posedge clk); #1;
    fu_bram_en = 0; host_req = 0;

    // Short by one window; hold the record while filling the queue
    @(posedge clk); #1 done_ready = 1'b0;
    fq.push_back('{675, 1'b0, 1'b0});
    sb.push_back('{3, 675, 2});
    exp_starts++;
    push_job(3, 3, 28, 'h200);
    t = 0;
    while (!done_valid && t < 1500) begin @(negedge clk); t++; end
    chk("err2_done_seen", 32'(done_valid), 32'd1);
    base_starts = n_starts;
    for (int j = 0; j < 4; j++) begin
      fq.push_back('{nwin[j], same[j], 1'b0});
      sb.push_back('{j, nwin[j], 0});
      exp_starts++;
      push_job(j, kers[j], imgs[j], 16 * j);
    end
    @(negedge clk);
    chk("queue_full_ready", 32'(job_ready), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(done_valid), 32'd1);
    end
    chk("hold_no_start", 32'(n_starts), 32'(base_starts));
    @(posedge clk); #1 done_ready = 1'b1;
    fq.push_back('{nwin[4], same[4], 1'b0});
    sb.push_back('{4, nwin[4], 0});
    exp_starts++;
    push_job(4, kers[4], imgs[4], 64);
    drain();

`ifdef CONV_WDOG_EN
    // Watchdog: frame_done never arrives
    fq.push_back('{5, 1'b0, 1'b1});
    sb.push_back('{11, 5, 3});
    exp_starts++;
    push_job(11, 3, 8, 'h40);
    t = 0;
    while (!fu_start && t < 10) begin @(negedge clk); t++; end
    chk("wdog_start_seen", 32'(fu_start), 32'd1);
    repeat (63) @(negedge clk);
    chk("wdog_before_limit", 32'(done_valid), 32'd0);
    @(negedge clk);
    chk("wdog_at_limit", 32'(done_valid), 32'd1);
    drain();
`endif

    // Reset mid-run with a second job still queued
    fq.push_back('{3, 1'b0, 1'b1});
    exp_starts++;
    push_job(9, 3, 8, 0);
    push_job(10, 2, 4, 0);
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    chk("abort_job_ready", 32'(job_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done_valid", 32'(done_valid), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("flushed_idle", 32'(busy), 32'd0);
    end

    chk("fu_start_count", 32'(n_starts), 32'(exp_starts));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
